// File: rtl/dispatch_allocator_pkg.sv
// Shared types for the dispatch allocator: station encoding, dispatch payload and
// the output-register state enum.
package dispatch_allocator_pkg;

  localparam int RS_NUM    = 4;
  // Widest ROB tag the payload can carry; narrower tags are zero-extended.
  localparam int MAX_TAG_W = 8;

  typedef enum logic [1:0] {
    RS_ALU    = 2'b00,
    RS_BRANCH = 2'b01,
    RS_LDST   = 2'b10,
    RS_UPPER  = 2'b11
  } rs_station_e;

  typedef enum logic {
    ST_IDLE,
    ST_EMIT
  } emit_state_e;

  typedef struct packed {
    logic                 stationRequest;
    rs_station_e          rsStation;
    logic [1:0]           aluOp;
    logic [2:0]           immSrc;
    logic                 useImm;
    logic                 regWrite;
    logic                 memWrite;
    logic                 isJAL;
    logic                 isLUI;
    logic                 isAUIPC;
    logic                 isJALR;
    logic [MAX_TAG_W-1:0] robTag;
  } dispatch_payload_t;

  function automatic logic [RS_NUM-1:0] station_onehot(input rs_station_e s);
    logic [RS_NUM-1:0] r;
    r    = '0;
    r[s] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/dispatch_allocator_rs_credit_counter.sv
// Free-entry counter for one reservation station: reserve on accept, release on
// rsFree, saturating at both ends, refilled by flush.
module rs_credit_counter #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          take,
  input  logic          rel,
  input  logic          flush,
  output logic [CW-1:0] credit
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credit <= FULL;
    end else if (flush) begin
      credit <= FULL;
    end else if (take && !rel && credit != '0) begin
      credit <= credit - 1'b1;
    end else if (rel && !take && credit != FULL) begin
      credit <= credit + 1'b1;
    end
  end

endmodule

// File: rtl/dispatch_allocator.sv
// Dispatch allocator: credit-gated hand-off of decoded instructions to four
// reservation stations or the ROB bypass. Optional DISPATCH_STALL_STATS_EN adds stall counters.
module dispatch_allocator
  import dispatch_allocator_pkg::*;
#(
  parameter int RS_DEPTH = 4,
  parameter int TAG_W    = 4,
  localparam int CW      = $clog2(RS_DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       decValid,
  output logic                       decReady,
  input  logic                       stationRequest,
  input  logic [1:0]                 RSstation,
  input  logic [1:0]                 aluOp,
  input  logic [2:0]                 immSrc,
  input  logic                       useImm,
  input  logic                       regWrite,
  input  logic                       memWrite,
  input  logic                       isJAL,
  input  logic                       isLUI,
  input  logic                       isAUIPC,
  input  logic                       isJALR,
  input  logic [TAG_W-1:0]           robTag,
  output logic [RS_NUM-1:0]          rsWe,
  output dispatch_payload_t          rsPayload,
  output logic                       bypValid,
  input  logic [RS_NUM-1:0]          rsFree,
  input  logic                       flush,
`ifdef DISPATCH_STALL_STATS_EN
  output logic [RS_NUM-1:0][31:0]    stallCount,
`endif
  output logic [RS_NUM-1:0][CW-1:0]  credit
);

  emit_state_e       state;
  dispatch_payload_t payload_next;
  logic [RS_NUM-1:0] sel;
  logic [RS_NUM-1:0] take;
  logic              accept;

  assign sel      = station_onehot(rs_station_e'(RSstation));
  assign decReady = !flush && (!stationRequest || credit[RSstation] != '0);
  assign accept   = decValid && decReady;
  // Credit is reserved in the acceptance cycle so back-to-back requests see it.
  assign take     = sel & {RS_NUM{accept && stationRequest}};

  always_comb begin
    payload_next                = '0;
    payload_next.stationRequest = stationRequest;
    payload_next.rsStation      = rs_station_e'(RSstation);
    payload_next.aluOp          = aluOp;
    payload_next.immSrc         = immSrc;
    payload_next.useImm         = useImm;
    payload_next.regWrite       = regWrite;
    payload_next.memWrite       = memWrite;
    payload_next.isJAL          = isJAL;
    payload_next.isLUI          = isLUI;
    payload_next.isAUIPC        = isAUIPC;
    payload_next.isJALR         = isJALR;
    payload_next.robTag         = MAX_TAG_W'(robTag);
  end

  for (genvar gi = 0; gi < RS_NUM; gi++) begin : g_credit
    rs_credit_counter #(
      .DEPTH (RS_DEPTH),
      .CW    (CW)
    ) u_credit (
      .clk     (clk),
      .reset_n (reset_n),
      .take    (take[gi]),
      .rel     (rsFree[gi]),
      .flush   (flush),
      .credit  (credit[gi])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      rsWe      <= '0;
      bypValid  <= 1'b0;
      rsPayload <= '0;
    end else if (flush) begin
      state    <= ST_IDLE;
      rsWe     <= '0;
      bypValid <= 1'b0;
    end else if (accept) begin
      state     <= ST_EMIT;
      rsWe      <= stationRequest ? sel : '0;
      bypValid  <= !stationRequest;
      rsPayload <= payload_next;
    end else begin
      case (state)
        // Outputs are already quiet in IDLE; only EMIT has a strobe to retire.
        ST_EMIT: begin
          state    <= ST_IDLE;
          rsWe     <= '0;
          bypValid <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DISPATCH_STALL_STATS_EN
  for (genvar gi = 0; gi < RS_NUM; gi++) begin : g_stall
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        stallCount[gi] <= '0;
      end else if (decValid && stationRequest && sel[gi] && credit[gi] == '0
                   && stallCount[gi] != '1) begin
        stallCount[gi] <= stallCount[gi] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dispatch_allocator.sv
// Table-driven bench for dispatch_allocator with a scoreboard queue of expected
// registered outputs, plus hand sequences for reset during EMIT.
module tb_dispatch_allocator;
  import dispatch_allocator_pkg::*;

  localparam int RS_DEPTH = 4;
  localparam int TAG_W    = 4;
  localparam int CW       = 3;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic                      decValid, decReady, stationRequest;
  logic [1:0]                RSstation, aluOp;
  logic [2:0]                immSrc;
  logic                      useImm, regWrite, memWrite, isJAL, isLUI, isAUIPC, isJALR;
  logic [TAG_W-1:0]          robTag;
  logic [3:0]                rsWe;
  dispatch_payload_t         rsPayload;
  logic                      bypValid;
  logic [3:0]                rsFree;
  logic                      flush;
  logic [3:0][CW-1:0]        credit;
`ifdef DISPATCH_STALL_STATS_EN
  logic [3:0][31:0]          stallCount;
`endif

  always #5 clk = ~clk;

  dispatch_allocator #(.RS_DEPTH(RS_DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset_n(reset_n), .decValid(decValid), .decReady(decReady),
    .stationRequest(stationRequest), .RSstation(RSstation), .aluOp(aluOp),
    .immSrc(immSrc), .useImm(useImm), .regWrite(regWrite), .memWrite(memWrite),
    .isJAL(isJAL), .isLUI(isLUI), .isAUIPC(isAUIPC), .isJALR(isJALR),
    .robTag(robTag), .rsWe(rsWe), .rsPayload(rsPayload), .bypValid(bypValid),
    .rsFree(rsFree), .flush(flush),
`ifdef DISPATCH_STALL_STATS_EN
    .stallCount(stallCount),
`endif
    .credit(credit)
  );

  typedef struct {
    logic       dv;
    logic       sr;
    logic [1:0] st;
    logic       fl;
    logic [3:0] fr;
    logic       exp_rdy;
    logic [3:0] exp_we;
    logic       exp_byp;
    logic [11:0] exp_cr;
  } vec_t;

  typedef struct {
    logic [3:0]        we;
    logic              byp;
    dispatch_payload_t pl;
    logic [11:0]       cr;
  } exp_t;

  vec_t              vecs[$];
  exp_t              sbq[$];
  dispatch_payload_t last_pl;
  int                total = 0;
  int                bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic dv, input logic sr, input logic [1:0] st, input logic fl,
                     input logic [3:0] fr, input logic rdy, input logic [3:0] we,
                     input logic byp, input logic [2:0] c3, input logic [2:0] c2,
                     input logic [2:0] c1, input logic [2:0] c0);
    vec_t v;
    v.dv = dv; v.sr = sr; v.st = st; v.fl = fl; v.fr = fr;
    v.exp_rdy = rdy; v.exp_we = we; v.exp_byp = byp; v.exp_cr = {c3, c2, c1, c0};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic dv, input logic sr, input logic [1:0] st,
                       input logic fl, input logic [3:0] fr);
    decValid = dv; stationRequest = sr; RSstation = st; flush = fl; rsFree = fr;
    aluOp    = 2'($urandom);  immSrc   = 3'($urandom);
    useImm   = 1'($urandom);  regWrite = 1'($urandom);
    memWrite = 1'($urandom);  isJAL    = 1'($urandom);
    isLUI    = 1'($urandom);  isAUIPC  = 1'($urandom);
    isJALR   = 1'($urandom);  robTag   = TAG_W'($urandom);
  endtask

  function automatic dispatch_payload_t cur_pl();
    dispatch_payload_t p;
    p = '0;
    p.stationRequest = stationRequest; p.rsStation = rs_station_e'(RSstation);
    p.aluOp = aluOp; p.immSrc = immSrc; p.useImm = useImm; p.regWrite = regWrite;
    p.memWrite = memWrite; p.isJAL = isJAL; p.isLUI = isLUI; p.isAUIPC = isAUIPC;
    p.isJALR = isJALR; p.robTag = MAX_TAG_W'(robTag);
    return p;
  endfunction

  initial begin
    exp_t e;
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 1'b0, 4'b0000);

    //   dv sr st  fl fr       rdy we       byp  c3 c2 c1 c0
    add(1, 1, 2'd0, 0, 4'b0000, 1, 4'b0001, 0, 4, 4, 4, 3);
    add(1, 1, 2'd0, 0, 4'b0000, 1, 4'b0001, 0, 4, 4, 4, 2);
    add(1, 1, 2'd0, 0, 4'b0000, 1, 4'b0001, 0, 4, 4, 4, 1);
    add(1, 1, 2'd0, 0, 4'b0000, 1, 4'b0001, 0, 4, 4, 4, 0);
    add(1, 1, 2'd0, 0, 4'b0000, 0, 4'b0000, 0, 4, 4, 4, 0);
    add(1, 1, 2'd1, 0, 4'b0000, 1, 4'b0010, 0, 4, 4, 3, 0);
    add(1, 1, 2'd2, 0, 4'b0000, 1, 4'b0100, 0, 4, 3, 3, 0);
    add(1, 1, 2'd2, 0, 4'b0000, 1, 4'b0100, 0, 4, 2, 3, 0);
    add(1, 1, 2'd2, 0, 4'b0000, 1, 4'b0100, 0, 4, 1, 3, 0);
    add(1, 1, 2'd2, 0, 4'b0100, 1, 4'b0100, 0, 4, 1, 3, 0);
    add(0, 1, 2'd0, 0, 4'b0001, 0, 4'b0000, 0, 4, 1, 3, 1);
    add(1, 0, 2'd3, 0, 4'b0000, 1, 4'b0000, 1, 4, 1, 3, 1);
    add(1, 1, 2'd0, 1, 4'b0000, 0, 4'b0000, 0, 4, 4, 4, 4);
    add(1, 0, 2'd3, 0, 4'b0000, 1, 4'b0000, 1, 4, 4, 4, 4);
    add(0, 0, 2'd0, 0, 4'b1111, 1, 4'b0000, 0, 4, 4, 4, 4);
    add(1, 1, 2'd3, 0, 4'b0000, 1, 4'b1000, 0, 3, 4, 4, 4);
    add(1, 1, 2'd0, 0, 4'b1000, 1, 4'b0001, 0, 4, 4, 4, 3);
    add(0, 0, 2'd0, 1, 4'b1111, 0, 4'b0000, 0, 4, 4, 4, 4);
    add(1, 1, 2'd1, 0, 4'b0000, 1, 4'b0010, 0, 4, 4, 3, 4);
    add(0, 0, 2'd0, 0, 4'b0000, 1, 4'b0000, 0, 4, 4, 3, 4);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsWe", 64'(rsWe), 64'h0);
    chk("reset_byp", 64'(bypValid), 64'h0);
    chk("reset_credit", 64'(credit), 64'h924);
    chk("reset_payload", 64'(rsPayload), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    last_pl = '0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].dv, vecs[i].sr, vecs[i].st, vecs[i].fl, vecs[i].fr);
      #1;
      chk($sformatf("v%0d_decReady", i), 64'(decReady), 64'(vecs[i].exp_rdy));
      if (vecs[i].dv && vecs[i].exp_rdy) last_pl = cur_pl();
      e.we = vecs[i].exp_we; e.byp = vecs[i].exp_byp; e.pl = last_pl; e.cr = vecs[i].exp_cr;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
        chk($sformatf("v%0d_scoreboard_empty", i), 64'd1, 64'd0);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("v%0d_rsWe", i), 64'(rsWe), 64'(e.we));
        chk($sformatf("v%0d_bypValid", i), 64'(bypValid), 64'(e.byp));
        chk($sformatf("v%0d_credit", i), 64'(credit), 64'(e.cr));
        chk($sformatf("v%0d_payload", i), 64'(rsPayload), 64'(e.pl));
      end
    end

    // Reset asserted while a strobe is being emitted.
    @(negedge clk);
    drive(1'b1, 1'b1, 2'd0, 1'b0, 4'b0000);
    @(posedge clk);
    #1;
    chk("emit_rsWe", 64'(rsWe), 64'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_rsWe", 64'(rsWe), 64'h0);
    chk("rst_mid_byp", 64'(bypValid), 64'h0);
    chk("rst_mid_credit", 64'(credit), 64'h924);
    chk("rst_mid_payload", 64'(rsPayload), 64'h0);

    // First acceptance happens on the first edge after deassertion.
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post_rst_decReady", 64'(decReady), 64'h1);
    @(posedge clk);
    #1;
    chk("post_rst_rsWe", 64'(rsWe), 64'h1);
    chk("post_rst_credit", 64'(credit), 64'h923);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd0, 1'b0, 4'b0000);
    @(posedge clk);
    #1;
    chk("emit_to_idle_rsWe", 64'(rsWe), 64'h0);
    chk("emit_to_idle_credit", 64'(credit), 64'h923);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
